exc_ctrl: RTL and testbench

- Parametrised, registered successor to the combinational exception-type encoder. Sits at the MEM/commit boundary of the MIPS pipeline.
- Synchronises and latches hardware interrupts, and resolves the highest-priority exception or ERET for the committing instruction.
- Issues a one-cycle commit pulse with ExcCode, EPC, BadVAddr and BD to CP0, and holds a pipeline flush for a programmable number of cycles with the redirect PC.

---
 rtl/exc_pkg.sv | 32 +++
 rtl/int_sync.sv | 33 +++
 rtl/exc_ctrl.sv | 174 +++++++++++++++++
 tb/tb_exc_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the commit-stage exception controller.
package exc_pkg;

   typedef enum logic [4:0] {
      INT  = 5'h00,
      ADEL = 5'h04,
      ADES = 5'h05,
      SYS  = 5'h08,
      BP   = 5'h09,
      RI   = 5'h0A,
      OV   = 5'h0C,
      TR   = 5'h0D
   } exc_code_e;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } exc_state_e;

   // Bit positions inside exc_flags_i = {eret, tr, ov, ri, bp, sys, ades, adel_data}
   localparam int F_ADEL_D = 0;
   localparam int F_ADES   = 1;
   localparam int F_SYS    = 2;
   localparam int F_BP     = 3;
   localparam int F_RI     = 4;
   localparam int F_OV     = 5;
   localparam int F_TR     = 6;
   localparam int F_ERET   = 7;

   localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

endpackage

// File: rtl/int_sync.sv
// One hardware interrupt line: multi-flop synchroniser feeding a sticky pending bit.
module int_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   input  logic ack_i,
   output logic pending_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   pending_q, pending_d;

   // A synchronised set beats a same-cycle acknowledge.
   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], async_i};
      pending_d = sync_q[SYNC_STAGES-1] | (pending_q & ~ack_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         pending_q <= pending_d;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/exc_ctrl.sv
// Registered exception/ERET resolver at the MEM/commit boundary: interrupt latching,
// priority selection, one-cycle CP0 commit pulse and a timed pipeline flush.
module exc_ctrl
   import exc_pkg::*;
#(
   parameter int          NUM_HW_INT   = 6,
   parameter int          SYNC_STAGES  = 2,
   parameter int          FLUSH_CYCLES = 2,
   parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NUM_HW_INT-1:0] hw_int_i,
   input  logic [NUM_HW_INT-1:0] int_ack_i,
   input  logic                  inst_valid_i,
   input  logic                  stall_i,
   input  logic [31:0]           pc_i,
   input  logic                  in_delay_slot_i,
   input  logic [7:0]            exc_flags_i,
   input  logic                  if_adel_i,
   input  logic [31:0]           bad_addr_i,
   input  logic [31:0]           cp0_status_i,
   input  logic [31:0]           cp0_cause_i,
   input  logic [31:0]           cp0_epc_i,
   output logic                  exc_valid_o,
   output logic [4:0]            exc_code_o,
   output logic                  eret_o,
   output logic [31:0]           epc_o,
   output logic [31:0]           badvaddr_o,
   output logic                  bd_o,
   output logic [NUM_HW_INT-1:0] int_pending_o,
   output logic                  flush_o,
   output logic [31:0]           new_pc_o,
   output logic                  busy_o
);

   localparam int         CW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

   exc_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          exc_valid_q, exc_valid_d;
   logic          eret_q, eret_d;
   exc_code_e     code_q, code_d;
   logic [31:0]   epc_q, epc_d;
   logic [31:0]   bad_q, bad_d;
   logic          bd_q, bd_d;
   logic [31:0]   npc_q, npc_d;

   logic [NUM_HW_INT-1:0] pending;
   logic [5:0]            hw_ip;
   logic                  int_req, take, busy;
   logic                  sel_exc, sel_bad_we;
   exc_code_e             sel_code;
   logic [31:0]           sel_bad;

   for (genvar g = 0; g < NUM_HW_INT; g++) begin : g_int
      int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .async_i   (hw_int_i[g]),
         .ack_i     (int_ack_i[g]),
         .pending_o (pending[g])
      );
   end

   always_comb begin
      hw_ip                   = '0;
      hw_ip[NUM_HW_INT-1:0]   = pending;
   end

   assign busy    = (state_q == FLUSH);
   assign int_req = (|({hw_ip, cp0_cause_i[9:8]} & cp0_status_i[15:8]))
                    & ~cp0_status_i[1] & cp0_status_i[0];
   assign take    = inst_valid_i & ~stall_i & ~busy & (int_req | (|exc_flags_i) | if_adel_i);

   // Priority encoder; ERET is the fallthrough when nothing else is raised.
   always_comb begin
      sel_exc    = 1'b1;
      sel_code   = INT;
      sel_bad_we = 1'b0;
      sel_bad    = bad_addr_i;
      if (int_req)                         sel_code = INT;
      else if (if_adel_i) begin
         sel_code   = ADEL;
         sel_bad_we = 1'b1;
         sel_bad    = pc_i;
      end
      else if (exc_flags_i[F_RI])          sel_code = RI;
      else if (exc_flags_i[F_SYS])         sel_code = SYS;
      else if (exc_flags_i[F_BP])          sel_code = BP;
      else if (exc_flags_i[F_OV])          sel_code = OV;
      else if (exc_flags_i[F_TR])          sel_code = TR;
      else if (exc_flags_i[F_ADEL_D]) begin
         sel_code   = ADEL;
         sel_bad_we = 1'b1;
      end
      else if (exc_flags_i[F_ADES]) begin
         sel_code   = ADES;
         sel_bad_we = 1'b1;
      end
      else                                 sel_exc  = 1'b0;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      exc_valid_d = 1'b0;
      eret_d      = 1'b0;
      code_d      = code_q;
      epc_d       = epc_q;
      bad_d       = bad_q;
      bd_d        = bd_q;
      npc_d       = npc_q;
      unique case (state_q)
         IDLE: if (take) begin
            state_d = FLUSH;
            cnt_d   = CNT_INIT;
            if (sel_exc) begin
               exc_valid_d = 1'b1;
               code_d      = sel_code;
               epc_d       = in_delay_slot_i ? (pc_i - 32'd4) : pc_i;
               bd_d        = in_delay_slot_i;
               npc_d       = EXC_VECTOR;
               if (sel_bad_we) bad_d = sel_bad;
            end else begin
               eret_d = 1'b1;
               npc_d  = cp0_epc_i;
            end
         end
         FLUSH: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         exc_valid_q <= 1'b0;
         eret_q      <= 1'b0;
         code_q      <= INT;
         epc_q       <= '0;
         bad_q       <= '0;
         bd_q        <= 1'b0;
         npc_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         exc_valid_q <= exc_valid_d;
         eret_q      <= eret_d;
         code_q      <= code_d;
         epc_q       <= epc_d;
         bad_q       <= bad_d;
         bd_q        <= bd_d;
         npc_q       <= npc_d;
      end
   end

   assign exc_valid_o   = exc_valid_q;
   assign eret_o        = eret_q;
   assign exc_code_o    = code_q;
   assign epc_o         = epc_q;
   assign badvaddr_o    = bad_q;
   assign bd_o          = bd_q;
   assign int_pending_o = pending;
   assign flush_o       = busy;
   assign busy_o        = busy;
   assign new_pc_o      = npc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed + random bench for exc_ctrl against a cycle-level behavioural model.
module tb_exc_ctrl;

   localparam int          NHI = 6;
   localparam int          SS  = 2;
   localparam int          FC  = 2;
   localparam logic [31:0] VEC = 32'hBFC0_0380;

   logic clk = 1'b0;
   logic rst_n;
   logic [NHI-1:0] hw_int, int_ack;
   logic inst_valid, stall, dslot, if_adel;
   logic [31:0] pc, bad_addr, status, cause, cp0_epc;
   logic [7:0] flags;

   logic exc_valid, eret, bd, flush, busy;
   logic [4:0] exc_code;
   logic [31:0] epc, badv, new_pc;
   logic [NHI-1:0] pend;

   exc_ctrl #(.NUM_HW_INT(NHI), .SYNC_STAGES(SS), .FLUSH_CYCLES(FC), .EXC_VECTOR(VEC)) dut (
      .clk_i(clk), .rst_ni(rst_n), .hw_int_i(hw_int), .int_ack_i(int_ack),
      .inst_valid_i(inst_valid), .stall_i(stall), .pc_i(pc), .in_delay_slot_i(dslot),
      .exc_flags_i(flags), .if_adel_i(if_adel), .bad_addr_i(bad_addr),
      .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(cp0_epc),
      .exc_valid_o(exc_valid), .exc_code_o(exc_code), .eret_o(eret), .epc_o(epc),
      .badvaddr_o(badv), .bd_o(bd), .int_pending_o(pend), .flush_o(flush),
      .new_pc_o(new_pc), .busy_o(busy));

   always #5 clk = ~clk;

   int ntot = 0, npass = 0, nfail = 0;

   // Model state
   logic [NHI-1:0] hist[$];
   logic [NHI-1:0] m_pend;
   int             m_left;
   logic           m_exv, m_erv, m_bd;
   logic [4:0]     m_code;
   logic [31:0]    m_epc, m_bad, m_npc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back('0);
      m_pend = '0; m_left = 0; m_exv = 0; m_erv = 0; m_bd = 0;
      m_code = '0; m_epc = '0; m_bad = '0; m_npc = '0;
   endtask

   task automatic check_all();
      chk("exc_valid", 32'(exc_valid), 32'(m_exv));
      chk("eret", 32'(eret), 32'(m_erv));
      chk("flush", 32'(flush), 32'(m_left > 0));
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("pending", 32'(pend), 32'(m_pend));
      chk("code", 32'(exc_code), 32'(m_code));
      chk("epc", epc, m_epc);
      chk("bd", 32'(bd), 32'(m_bd));
      chk("badvaddr", badv, m_bad);
      chk("new_pc", new_pc, m_npc);
   endtask

   // One clock: evaluate the rules on the current inputs, advance, compare.
   task automatic tick();
      logic [7:0]     ip;
      logic           ireq, tk;
      logic [NHI-1:0] synced, pend_nx;
      ip      = {2'b00, m_pend, cause[9:8]};
      ireq    = (|(ip & status[15:8])) && !status[1] && status[0];
      tk      = inst_valid && !stall && (m_left == 0) && (ireq || (|flags) || if_adel);
      synced  = hist.pop_front();
      hist.push_back(hw_int);
      pend_nx = synced | (m_pend & ~int_ack);
      @(posedge clk); #1;
      m_pend = pend_nx;
      m_exv = 0; m_erv = 0;
      if (m_left > 0) m_left--;
      if (tk) begin
         m_left = FC;
         if (ireq || if_adel || (|flags[6:0])) begin
            m_exv = 1;
            m_epc = dslot ? pc - 32'd4 : pc;
            m_bd  = dslot;
            m_npc = VEC;
            if (ireq)          m_code = 5'h00;
            else if (if_adel)  begin m_code = 5'h04; m_bad = pc; end
            else if (flags[4]) m_code = 5'h0A;
            else if (flags[2]) m_code = 5'h08;
            else if (flags[3]) m_code = 5'h09;
            else if (flags[5]) m_code = 5'h0C;
            else if (flags[6]) m_code = 5'h0D;
            else if (flags[0]) begin m_code = 5'h04; m_bad = bad_addr; end
            else               begin m_code = 5'h05; m_bad = bad_addr; end
         end else begin
            m_erv = 1;
            m_npc = cp0_epc;
         end
      end
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n = 0; hw_int = '0; int_ack = '0; inst_valid = 0; stall = 0; dslot = 0;
      if_adel = 0; pc = '0; bad_addr = '0; status = '0; cause = '0; cp0_epc = '0; flags = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1;
      #1;
      check_all();
      ticks(2);

      // Hardware interrupt on line 2
      status = 32'h0000_1001; inst_valid = 1; pc = 32'h8000_0100;
      hw_int = 6'b000100; tick();
      hw_int = '0; ticks(3);
      chk("int_exc_valid", 32'(exc_valid), 32'd1);
      chk("int_code", 32'(exc_code), 32'h00);
      chk("int_epc", epc, 32'h8000_0100);
      chk("int_newpc", new_pc, 32'hBFC0_0380);
      int_ack = 6'b000100; tick();
      int_ack = '0; ticks(3);

      // ov + ades in a delay slot: ov wins, BadVAddr untouched
      flags = 8'b0010_0010; pc = 32'h8000_0204; dslot = 1; bad_addr = 32'h0000_0013;
      tick();
      chk("ov_code", 32'(exc_code), 32'h0C);
      chk("ov_epc", epc, 32'h8000_0200);
      chk("ov_bd", 32'(bd), 32'd1);
      chk("ov_badv", badv, 32'h0);
      flags = '0; dslot = 0; ticks(3);

      // adel_data alone
      flags = 8'b0000_0001; bad_addr = 32'h8000_1001; tick();
      chk("adel_code", 32'(exc_code), 32'h04);
      chk("adel_badv", badv, 32'h8000_1001);
      flags = '0; ticks(3);

      // ERET
      flags = 8'b1000_0000; cp0_epc = 32'h8000_0300; tick();
      chk("eret_pulse", 32'(eret), 32'd1);
      chk("eret_noexc", 32'(exc_valid), 32'd0);
      chk("eret_newpc", new_pc, 32'h8000_0300);
      flags = '0; ticks(3);

      // Pending interrupt held off by a stall
      hw_int = 6'b000100; stall = 1; ticks(5);
      chk("stall_notake", 32'(exc_valid), 32'd0);
      stall = 0; tick();
      chk("stall_release_take", 32'(exc_valid), 32'd1);
      hw_int = '0; status = 32'h0000_1000;
      int_ack = 6'b000100; ticks(4);
      int_ack = '0; tick();
      chk("ack_cleared", 32'(pend[2]), 32'd0);
      hw_int = 6'b000100; ticks(SS);
      int_ack = 6'b000100; tick();
      chk("set_beats_ack", 32'(pend[2]), 32'd1);
      int_ack = '0; hw_int = '0;

      // EXL masks the interrupt but not a syscall
      status = 32'h0000_1003; ticks(2);
      chk("exl_mask", 32'(exc_valid), 32'd0);
      flags = 8'b0000_0100; tick();
      chk("exl_sys", 32'(exc_code), 32'h08);
      flags = '0; ticks(2);

      // Reset while flushing
      status = 32'h0000_1001; tick();
      chk("preflush", 32'(flush), 32'd1);
      #2 rst_n = 0;
      #1;
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_newpc", new_pc, 32'd0);
      chk("rst_pend", 32'(pend), 32'd0);
      model_reset();
      @(negedge clk); rst_n = 1;
      status = '0; ticks(2);

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         inst_valid = ($urandom_range(0, 3) != 0);
         stall      = ($urandom_range(0, 3) == 0);
         dslot      = $urandom_range(0, 1) == 1;
         pc         = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
         bad_addr   = $urandom();
         cp0_epc    = $urandom() & 32'hFFFF_FFFC;
         flags      = ($urandom_range(0, 5) == 0) ? 8'($urandom()) : 8'h00;
         if_adel    = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 7) == 0) hw_int = NHI'($urandom());
         int_ack    = ($urandom_range(0, 9) == 0) ? NHI'($urandom()) : '0;
         cause      = ($urandom_range(0, 9) == 0) ? {22'h0, 2'($urandom()), 8'h0} : '0;
         if ($urandom_range(0, 15) == 0)
            status = {16'h0, 8'($urandom()), 6'h0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7)};
         tick();
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
